mac_result_collector: RTL and testbench

- Downstream stage of the MAC controller.
- Issues one-cycle start pulses to the MAC, waits for its done pulse, and captures the accumulated result into a small register FIFO.
- Presents results to the consumer through a valid/ready interface.
- Credit-gated: a MAC run is launched only when a FIFO slot is guaranteed, so results are never dropped in normal operation.

---
 rtl/mac_result_collector.sv | 175 +++++++++++++++++
 tb/tb_mac_result_collector.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_collector.sv
// mac_result_collector
//   Downstream stage of the MAC controller. Launches one MAC run at a time
//   (one-cycle mac_start), waits for the one-cycle mac_done, and pushes the
//   accumulated mac_result into a small register FIFO. The consumer drains
//   the FIFO through a valid/ready interface.
//
//   A run is launched only when a FIFO slot is guaranteed. Only one run is
//   ever outstanding, and the slot check happens in IDLE, so a push from
//   WAIT can never find the FIFO full.
//
//   Optional feature: define MAC_RESULT_TIMEOUT_EN to bound the WAIT state
//   to TIMEOUT_CYC cycles. On expiry err is set, nothing is written, and the
//   FSM returns to IDLE. Without the macro, WAIT lasts until mac_done.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         asynchronous reset, active low (0 = reset)
//   run         level enable; while high, keep launching MAC runs
//   mac_start   one-cycle start pulse to the MAC controller (registered)
//   mac_done    one-cycle done pulse from the MAC controller
//   mac_result  MAC accumulator value, valid in the mac_done cycle
//   out_valid   FIFO non-empty
//   out_data    head-of-FIFO entry (don't-care while out_valid = 0)
//   out_ready   consumer accepts the head when out_valid = 1
//   count       entries currently stored (0..DEPTH)
//   busy        a MAC run is outstanding (ISSUE or WAIT)
//   err         sticky: unexpected mac_done or WAIT timeout; cleared by reset
module mac_result_collector #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mac_start,
    input  logic              mac_done,
    input  logic [DATA_W-1:0] mac_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [PTR_W:0]    count,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic push;
    logic pop;
    logic can_issue;
    logic unexpected;
    logic timeout;

    assign out_valid  = (count != '0);
    // NOTE: the head is read combinationally from storage, so out_data follows
    // rd_ptr with no extra pipeline stage; it is meaningless while out_valid=0.
    assign out_data   = mem[rd_ptr];

    assign pop        = out_valid && out_ready;
    assign push       = (state == S_WAIT) && mac_done;
    // A slot freed by this cycle's pop counts as free for the issue decision.
    assign can_issue  = run && ((count != FULL_CNT) || pop);
    // A done outside WAIT (including one from a run orphaned by reset) is
    // dropped and flagged.
    assign unexpected = mac_done && (state != S_WAIT);

`ifdef MAC_RESULT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] wait_cyc;

    // Cleared while in ISSUE so it reads 0 on the first WAIT cycle; expiry
    // fires on the TIMEOUT_CYC-th WAIT cycle that has no mac_done.
    assign timeout = (state == S_WAIT) && !mac_done &&
                     (wait_cyc == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cyc <= '0;
        end else if (state == S_ISSUE) begin
            wait_cyc <= '0;
        end else if (state == S_WAIT) begin
            wait_cyc <= wait_cyc + TMR_W'(1);
        end
    end
`else
    // No timeout in this build: the comparison is constant false and only
    // keeps the timeout limit referenced.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // Control FSM with registered mac_start and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mac_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (can_issue) begin
                        state     <= S_ISSUE;
                        mac_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (push || timeout) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pointers and occupancy. Pointers wrap naturally because DEPTH = 2**PTR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (unexpected || timeout) begin
            err <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; entries are only ever observed after
    // a push has written them, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= mac_result;
        end
    end

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector. A behavioural model (FIFO
// queue plus "run in flight" flags) predicts every output; a MAC responder
// answers mac_start pulses with done after a chosen latency.
module tb_mac_result_collector;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              mac_start;
    logic              mac_done;
    logic [DATA_W-1:0] mac_result;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [PTR_W:0]    count;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    mac_result_collector #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mac_start (mac_start),
        .mac_done  (mac_done),
        .mac_result(mac_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: stored results, whether a start is due this cycle,
    // whether a run is awaiting its done, and the sticky error.
    logic [DATA_W-1:0] m_q[$];
    bit                m_start;
    bit                m_waiting;
    bit                m_err;

    // MAC responder state.
    logic [DATA_W-1:0] res_q[$];
    bit                auto_mac;
    bit                rand_lat;
    int                cd;
    int                n_starts;

    // Advance one clock: drive responder done, update the model with the
    // inputs seen at the edge, then return at the following falling edge.
    task automatic tick();
        bit was_waiting;
        bit pop_now;
        if (auto_mac && cd == 0) begin
            mac_done   = 1'b1;
            mac_result = (res_q.size() != 0) ? res_q.pop_front() : DATA_W'($urandom);
            cd         = -1;
        end else if (cd > 0) begin
            cd--;
        end
        @(posedge clk);
        was_waiting = m_waiting;
        pop_now     = out_ready && (m_q.size() != 0);
        if (pop_now) void'(m_q.pop_front());
        if (mac_done && !was_waiting) m_err = 1'b1;
        if (m_start) begin
            m_start   = 1'b0;
            m_waiting = 1'b1;
        end else if (m_waiting) begin
            if (mac_done) begin
                m_q.push_back(mac_result);
                m_waiting = 1'b0;
            end
        end else if (run && m_q.size() < DEPTH) begin
            m_start = 1'b1;
        end
        @(negedge clk);
        mac_done = 1'b0;
        if (mac_start === 1'b1) begin
            n_starts++;
            if (auto_mac) cd = rand_lat ? int'($urandom_range(0, 3)) + 1 : 3 + (n_starts % 2);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        run        = 1'b0;
        out_ready  = 1'b0;
        mac_done   = 1'b0;
        mac_result = '0;
        auto_mac   = 1'b0;
        rand_lat   = 1'b0;
        cd         = -1;
        n_starts   = 0;
        m_q.delete();
        res_q.delete();
        m_start    = 1'b0;
        m_waiting  = 1'b0;
        m_err      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++; if ({mac_start, busy, out_valid, err} !== 4'b0000) begin bad++;
            $display("FAIL reset.flags got=%b exp=0000", {mac_start, busy, out_valid, err}); end
        total++; if (count !== '0) begin bad++;
            $display("FAIL reset.count got=%0d exp=0", count); end
        do_reset();
        run = 1'b1;
        total++; if (mac_start !== 1'b0) begin bad++;
            $display("FAIL reset.start_cycle1 got=%b exp=0", mac_start); end
        tick();
        total++; if (mac_start !== 1'b1 || busy !== 1'b1) begin bad++;
            $display("FAIL reset.start_cycle2 got start=%b busy=%b exp 1 1", mac_start, busy); end
        tick();
        total++; if (mac_start !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL reset.wait got start=%b busy=%b exp 0 1", mac_start, busy); end
    endtask

    task automatic test_fill();
        do_reset();
        auto_mac = 1'b1;
        res_q    = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        run      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            total++; if (count !== (PTR_W + 1)'(m_q.size())) begin bad++;
                $display("FAIL fill.count cyc=%0d got=%0d exp=%0d", i, count, m_q.size()); end
            total++; if (mac_start !== m_start || busy !== (m_start || m_waiting)) begin bad++;
                $display("FAIL fill.ctrl cyc=%0d got start=%b busy=%b exp %b %b",
                         i, mac_start, busy, m_start, m_start || m_waiting); end
            if (m_q.size() != 0) begin
                total++; if (out_data !== m_q[0]) begin bad++;
                    $display("FAIL fill.data cyc=%0d got=%h exp=%h", i, out_data, m_q[0]); end
            end
        end
        total++; if (count !== 3'd4 || n_starts != 4 || err !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL fill.final got count=%0d starts=%0d err=%b busy=%b exp 4 4 0 0",
                     count, n_starts, err, busy); end
    endtask

    task automatic test_pop_one();
        bit seen;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h0011) begin bad++;
            $display("FAIL pop.head got valid=%b data=%h exp 1 0011", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd3 || out_data !== 16'h0022) begin bad++;
            $display("FAIL pop.after got count=%0d data=%h exp 3 0022", count, out_data); end
        seen = (mac_start === 1'b1);
        if (!seen) begin
            tick();
            seen = (mac_start === 1'b1);
        end
        total++; if (!seen) begin bad++;
            $display("FAIL pop.restart got no mac_start exp start within 2 cycles"); end
        repeat (12) tick();
        total++; if (count !== 3'd4 || out_data !== 16'h0022 || n_starts != 5) begin bad++;
            $display("FAIL pop.refill got count=%0d data=%h starts=%0d exp 4 0022 5",
                     count, out_data, n_starts); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        mac_done   = 1'b1;
        mac_result = 16'hA5A1;
        tick();
        total++; if (count !== 3'd1 || out_data !== 16'hA5A1) begin bad++;
            $display("FAIL b2b.first got count=%0d data=%h exp 1 a5a1", count, out_data); end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = (mac_start === 1'b1);
        end
        total++; if (!seen) begin bad++;
            $display("FAIL b2b.second_start got none exp mac_start within 4 cycles"); end
        run = 1'b0;
        tick();
        mac_done   = 1'b1;
        mac_result = 16'h5A52;
        out_ready  = 1'b1;
        total++; if (out_valid !== 1'b1 || out_data !== 16'hA5A1) begin bad++;
            $display("FAIL b2b.pop_head got valid=%b data=%h exp 1 a5a1", out_valid, out_data); end
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd1 || out_data !== 16'h5A52 || err !== 1'b0) begin bad++;
            $display("FAIL b2b.push_pop got count=%0d data=%h err=%b exp 1 5a52 0",
                     count, out_data, err); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (mac_start !== 1'b0 || busy !== 1'b0) begin bad++;
                $display("FAIL b2b.run_off cyc=%0d got start=%b busy=%b exp 0 0", i, mac_start, busy); end
        end
    endtask

    task automatic test_random_stream();
        do_reset();
        auto_mac = 1'b1;
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            run       = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            total++; if (count !== (PTR_W + 1)'(m_q.size()) || out_valid !== (m_q.size() != 0)) begin bad++;
                $display("FAIL stream.count cyc=%0d got=%0d valid=%b exp=%0d", i, count, out_valid, m_q.size()); end
            total++; if (mac_start !== m_start || busy !== (m_start || m_waiting) || err !== m_err) begin bad++;
                $display("FAIL stream.ctrl cyc=%0d got start=%b busy=%b err=%b exp %b %b %b", i,
                         mac_start, busy, err, m_start, m_start || m_waiting, m_err); end
            if (m_q.size() != 0) begin
                total++; if (out_data !== m_q[0]) begin bad++;
                    $display("FAIL stream.data cyc=%0d got=%h exp=%h", i, out_data, m_q[0]); end
            end
        end
    endtask

    task automatic test_unexpected_done();
        do_reset();
        tick();
        mac_done   = 1'b1;
        mac_result = 16'hBEEF;
        tick();
        total++; if (err !== 1'b1 || count !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL unexp.flag got err=%b count=%0d valid=%b busy=%b exp 1 0 0 0",
                     err, count, out_valid, busy); end
        res_q     = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505,
                      16'h0606, 16'h0707, 16'h0808, 16'h0909, 16'h0A0A};
        auto_mac  = 1'b1;
        run       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++; if (err !== 1'b1 || count !== (PTR_W + 1)'(m_q.size())) begin bad++;
                $display("FAIL unexp.sticky cyc=%0d got err=%b count=%0d exp 1 %0d", i, err, count, m_q.size()); end
            if (out_valid === 1'b1) begin
                total++; if (out_data === 16'hBEEF || out_data !== m_q[0]) begin bad++;
                    $display("FAIL unexp.data cyc=%0d got=%h exp=%h", i, out_data, m_q[0]); end
            end
        end
    endtask

    task automatic test_no_answer();
        do_reset();
        run = 1'b1;
        repeat (150) tick();
`ifdef MAC_RESULT_TIMEOUT_EN
        total++; if (err !== 1'b1 || n_starts < 2) begin bad++;
            $display("FAIL timeout.expire got err=%b starts=%0d exp err=1 starts>=2", err, n_starts); end
`else
        total++; if (busy !== 1'b1 || n_starts != 1 || err !== 1'b0) begin bad++;
            $display("FAIL timeout.none got busy=%b starts=%0d err=%b exp 1 1 0", busy, n_starts, err); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_pop_one();
        test_back_to_back();
        test_random_stream();
        test_unexpected_done();
        test_no_answer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
